// File: rtl/ray_dispatch_ctrl_if.sv
// Host/lane-facing signal bundle of the ray dispatcher.
// The dispatcher uses the slave modport; the host and lanes drive through master.
interface ray_dispatch_ctrl_if #(
    parameter int LANES = 2,
    parameter int ID_W  = 32
);
    logic                  io_start;
    logic [ID_W-1:0]       io_num_rays;
    logic [LANES-1:0]      io_issue_valid;
    logic [LANES-1:0]      io_issue_ready;
    logic [ID_W-1:0]       io_issue_ray_id;
    logic [LANES-1:0]      io_done_valid;
    logic                  io_busy;
    logic                  io_rtp_finish;
    logic                  io_err;
    logic [63:0]           io_cycle_count;
    logic [ID_W-1:0]       io_rays_issued;
    logic [ID_W-1:0]       io_rays_retired;

    modport slave (
        input  io_start, io_num_rays, io_issue_ready, io_done_valid,
        output io_issue_valid, io_issue_ray_id, io_busy, io_rtp_finish, io_err,
               io_cycle_count, io_rays_issued, io_rays_retired
    );

    modport master (
        output io_start, io_num_rays, io_issue_ready, io_done_valid,
        input  io_issue_valid, io_issue_ray_id, io_busy, io_rtp_finish, io_err,
               io_cycle_count, io_rays_issued, io_rays_retired
    );
endinterface

// File: rtl/ray_dispatch_ctrl.sv
// Round-robin, credit-limited dispatch of ray IDs onto traversal lanes,
// with frame-completion detection and performance counters.
module ray_dispatch_ctrl #(
    parameter int LANES   = 2,
    parameter int CREDITS = 4,
    parameter int ID_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    ray_dispatch_ctrl_if.slave io
);
    localparam int OW = $clog2(CREDITS + 1);
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [ID_W-1:0]          r_num, r_issued, r_retired, r_id;
    logic [63:0]              r_cyc;
    logic [PW-1:0]            r_ptr;
    logic [LANES-1:0][OW-1:0] r_out;
    logic [LANES-1:0]         r_vld;
    logic                     r_busy, r_finish, r_err;

    logic                     w_active, w_start_ok, w_fire_any, w_all_zero;
    logic [LANES-1:0]         w_fire, w_done_ok, w_done_bad, w_elig, w_vld_nxt;
    logic [LANES-1:0][OW-1:0] w_out_nxt;
    logic [ID_W-1:0]          w_iss_nxt, w_ret_inc, w_id_nxt;
    logic [PW-1:0]            w_ptr_nxt;
    logic                     w_busy_nxt, w_finish_nxt;

    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_start_ok = io.io_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // A done on a lane with nothing outstanding is still legal if that lane fires in the same cycle.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_fire[g]     = r_vld[g] & io.io_issue_ready[g];
        assign w_done_ok[g]  = w_active & io.io_done_valid[g] & ((r_out[g] != '0) | w_fire[g]);
        assign w_done_bad[g] = io.io_done_valid[g] & ~w_done_ok[g];
        // Retires free a credit only from the following cycle on.
        assign w_elig[g]     = (int'(r_out[g]) + int'(w_fire[g])) < CREDITS;
        assign w_out_nxt[g]  = (w_fire[g] & ~w_done_ok[g]) ? r_out[g] + OW'(1) :
                               (~w_fire[g] & w_done_ok[g]) ? r_out[g] - OW'(1) : r_out[g];
    end

    always_comb begin
        w_fire_any = |w_fire;
        w_all_zero = 1'b1;
        w_ret_inc  = '0;
        w_ptr_nxt  = r_ptr;
        for (int i = 0; i < LANES; i++) begin
            if (w_out_nxt[i] != '0) w_all_zero = 1'b0;
            if (w_done_ok[i]) w_ret_inc = w_ret_inc + ID_W'(1);
            if (w_fire[i]) w_ptr_nxt = PW'((i + 1) % LANES);
        end
        w_iss_nxt = r_issued + ID_W'(w_fire_any);
    end

    // Offer selection: held until it fires, then re-chosen from the advanced pointer.
    always_comb begin
        int j;
        j         = 0;
        w_vld_nxt = r_vld;
        w_id_nxt  = r_id;
        if (w_start_ok) begin
            w_vld_nxt = '0;
            w_id_nxt  = '0;
        end else if ((r_state != S_RUN) || (w_state_nxt != S_RUN)) begin
            w_vld_nxt = '0;
        end else if ((r_vld == '0) || w_fire_any) begin
            w_vld_nxt = '0;
            w_id_nxt  = w_iss_nxt;
            for (int i = 0; i < LANES; i++) begin
                j = (int'(w_ptr_nxt) + i) % LANES;
                if ((w_vld_nxt == '0) && w_elig[j]) w_vld_nxt[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (io.io_start) w_state_nxt = (io.io_num_rays == '0) ? S_DONE : S_RUN;
            S_RUN:          if (w_iss_nxt == r_num) w_state_nxt = S_DRAIN;
            S_DRAIN:        if (w_all_zero) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt   = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
        w_finish_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_num     <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_id      <= '0;
            r_cyc     <= '0;
            r_ptr     <= '0;
            r_out     <= '0;
            r_vld     <= '0;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_vld    <= w_vld_nxt;
            r_id     <= w_id_nxt;
            r_busy   <= w_busy_nxt;
            r_finish <= w_finish_nxt;
            if (w_done_bad != '0) r_err <= 1'b1;
            if (w_start_ok) begin
                r_num     <= io.io_num_rays;
                r_issued  <= '0;
                r_retired <= '0;
                r_cyc     <= '0;
                r_ptr     <= '0;
            end else if (w_active) begin
                r_issued  <= w_iss_nxt;
                r_retired <= r_retired + w_ret_inc;
                r_cyc     <= r_cyc + 64'd1;
                r_ptr     <= w_ptr_nxt;
                r_out     <= w_out_nxt;
            end
        end
    end

    assign io.io_issue_valid  = r_vld;
    assign io.io_issue_ray_id = r_id;
    assign io.io_busy         = r_busy;
    assign io.io_rtp_finish   = r_finish;
    assign io.io_err          = r_err;
    assign io.io_cycle_count  = r_cyc;
    assign io.io_rays_issued  = r_issued;
    assign io.io_rays_retired = r_retired;
endmodule

// File: tb/tb_ray_dispatch_ctrl.sv
// Randomized and directed bench for ray_dispatch_ctrl against a frame-level reference model.
module tb_ray_dispatch_ctrl;
    localparam int L = 2;
    localparam int C = 4;
    localparam int W = 32;

    logic clock, reset;
    ray_dispatch_ctrl_if #(.LANES(L), .ID_W(W)) io ();
    ray_dispatch_ctrl #(.LANES(L), .CREDITS(C), .ID_W(W)) dut (.clock(clock), .reset(reset), .io(io));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame phase (0 idle/done, 1 issuing, 2 draining), per-lane outstanding rays
    typedef struct { int lane; int due; } dq_t;
    dq_t         dq[$];
    int          fl_lane[$], fl_id[$], fl_cyc[$];
    int          m_ph, m_num, m_iss, m_ret, m_ptr, m_exp_id, m_start_cyc, tb_cyc;
    longint      m_cyc;
    bit          m_fin, m_err;
    int          m_out [L];
    bit          m_elig [L];
    logic [L-1:0] m_exp_vld, fire;
    int          dmode, dly_lo, dly_hi, rdy_pct;
    bit          rdy_rand;

    always @(posedge clock) begin
        if (reset) begin
            m_ph = 0; m_fin = 0; m_err = 0; m_num = 0; m_iss = 0; m_ret = 0; m_cyc = 0;
            m_ptr = 0; m_exp_vld = '0; m_exp_id = 0;
            for (int k = 0; k < L; k++) m_out[k] = 0;
            dq.delete();
        end else begin
            tb_cyc++;
            chk("valid", 64'(io.io_issue_valid), 64'(m_exp_vld));
            if (m_exp_vld != '0) chk("ray_id", 64'(io.io_issue_ray_id), 64'(m_exp_id));
            chk("busy", 64'(io.io_busy), 64'(m_ph != 0));
            chk("finish", 64'(io.io_rtp_finish), 64'(m_fin));
            chk("err", 64'(io.io_err), 64'(m_err));
            chk("issued", 64'(io.io_rays_issued), 64'(m_iss));
            chk("retired", 64'(io.io_rays_retired), 64'(m_ret));
            chk("cycles", io.io_cycle_count, 64'(m_cyc));
            fire = io.io_issue_valid & io.io_issue_ready;
            if (m_ph == 0) begin
                if (io.io_done_valid != '0) m_err = 1;
                if (io.io_start) begin
                    m_num = int'(io.io_num_rays); m_iss = 0; m_ret = 0; m_cyc = 0; m_ptr = 0;
                    m_exp_vld = '0; m_start_cyc = tb_cyc;
                    m_ph  = (m_num == 0) ? 0 : 1;
                    m_fin = (m_num == 0);
                end
            end else begin
                m_cyc++;
                for (int k = 0; k < L; k++) if (fire[k]) begin
                    fl_lane.push_back(k); fl_id.push_back(m_iss); fl_cyc.push_back(tb_cyc);
                    m_iss++; m_out[k]++; m_ptr = (k + 1) % L;
                    if (dmode == 1) dq.push_back('{k, tb_cyc + int'($urandom_range(dly_hi, dly_lo))});
                end
                for (int k = 0; k < L; k++) begin
                    chk("credit_bound", 64'(m_out[k] <= C), 64'(1));
                    m_elig[k] = m_out[k] < C;
                end
                for (int k = 0; k < L; k++) if (io.io_done_valid[k]) begin
                    if (m_out[k] > 0) begin m_out[k]--; m_ret++; end
                    else m_err = 1;
                end
                if (m_ph == 1) begin
                    if (m_iss == m_num) begin
                        m_ph = 2; m_exp_vld = '0;
                    end else if (m_exp_vld == '0 || fire != '0) begin
                        m_exp_vld = '0; m_exp_id = m_iss;
                        for (int i = 0; i < L; i++)
                            if (m_exp_vld == '0 && m_elig[(m_ptr + i) % L]) m_exp_vld[(m_ptr + i) % L] = 1'b1;
                    end
                end else begin
                    m_ph = 0;
                    for (int k = 0; k < L; k++) if (m_out[k] != 0) m_ph = 2;
                    if (m_ph == 0) m_fin = 1;
                end
            end
        end
    end

    task automatic step();
        logic [L-1:0] d;
        @(posedge clock); #1;
        d = '0;
        if (rdy_rand) for (int k = 0; k < L; k++) io.io_issue_ready[k] = ($urandom_range(99) < rdy_pct);
        if (dmode == 1) begin
            for (int k = 0; k < L; k++)
                for (int i = 0; i < dq.size(); i++)
                    if (dq[i].lane == k && dq[i].due <= tb_cyc) begin d[k] = 1'b1; dq.delete(i); break; end
        end else if (dmode == 2) begin
            for (int k = 0; k < L; k++) d[k] = (m_out[k] > 0) && ($urandom_range(1) == 1);
        end
        io.io_done_valid = d;
    endtask

    task automatic start_frame(input int n);
        io.io_num_rays = W'(n); io.io_start = 1'b1;
        step();
        io.io_start = 1'b0;
    endtask

    task automatic wait_fin(input int lim, input string tag);
        int n;
        n = 0;
        while (io.io_rtp_finish !== 1'b1 && n < lim) begin step(); n++; end
        chk(tag, 64'(io.io_rtp_finish), 64'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(io.io_issue_valid), 64'(0));
        chk({tag, "_id"}, 64'(io.io_issue_ray_id), 64'(0));
        chk({tag, "_busy"}, 64'(io.io_busy), 64'(0));
        chk({tag, "_finish"}, 64'(io.io_rtp_finish), 64'(0));
        chk({tag, "_err"}, 64'(io.io_err), 64'(0));
        chk({tag, "_cycles"}, io.io_cycle_count, 64'(0));
        chk({tag, "_issued"}, 64'(io.io_rays_issued), 64'(0));
        chk({tag, "_retired"}, 64'(io.io_rays_retired), 64'(0));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not end, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; tb_cyc = 0; dmode = 0; dly_lo = 1; dly_hi = 1; rdy_rand = 0; rdy_pct = 100;
        io.io_start = 1'b0; io.io_num_rays = '0; io.io_issue_ready = '0; io.io_done_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        step();

        // Zero rays
        chk("zero_pre_finish", 64'(io.io_rtp_finish), 64'(0));
        start_frame(0);
        chk("zero_finish", 64'(io.io_rtp_finish), 64'(1));
        chk("zero_busy", 64'(io.io_busy), 64'(0));
        chk("zero_valid", 64'(io.io_issue_valid), 64'(0));
        chk("zero_cycles", io.io_cycle_count, 64'(0));
        step();

        // Basic: ready high, each ray retired a few cycles after its fire
        io.io_issue_ready = '1; dmode = 1; dly_lo = 3; dly_hi = 3;
        fl_lane.delete(); fl_id.delete(); fl_cyc.delete();
        start_frame(4);
        wait_fin(100, "basic_timeout");
        chk("basic_nfires", 64'(fl_id.size()), 64'(4));
        if (fl_id.size() == 4) begin
            chk("basic_latency", 64'(fl_cyc[0]), 64'(m_start_cyc + 2));
            for (int i = 0; i < 4; i++) begin
                chk("basic_lane", 64'(fl_lane[i]), 64'(i % 2));
                chk("basic_id", 64'(fl_id[i]), 64'(i));
                chk("basic_consec", 64'(fl_cyc[i]), 64'(fl_cyc[0] + i));
            end
        end
        chk("basic_issued", 64'(io.io_rays_issued), 64'(4));
        chk("basic_retired", 64'(io.io_rays_retired), 64'(4));
        step();

        // Credit stall
        dmode = 0; fl_id.delete();
        start_frame(10);
        repeat (15) step();
        chk("stall_nfires", 64'(fl_id.size()), 64'(8));
        chk("stall_valid", 64'(io.io_issue_valid), 64'(0));
        io.io_done_valid = 2'b10;
        step();
        chk("stall_valid_same_edge", 64'(io.io_issue_valid), 64'(0));
        step();
        chk("stall_reoffer_lane", 64'(io.io_issue_valid), 64'(2'b10));
        chk("stall_reoffer_id", 64'(io.io_issue_ray_id), 64'(8));
        dmode = 2;
        wait_fin(300, "stall_timeout");
        chk("stall_issued", 64'(io.io_rays_issued), 64'(10));
        chk("stall_retired", 64'(io.io_rays_retired), 64'(10));
        step();

        // Backpressure on lane 0
        dmode = 0; io.io_issue_ready = '0;
        start_frame(3);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(io.io_issue_valid), 64'(2'b01));
            chk("bp_id", 64'(io.io_issue_ray_id), 64'(0));
            step();
        end
        io.io_issue_ready = '1; dmode = 1; dly_lo = 1; dly_hi = 4;
        wait_fin(100, "bp_timeout");
        chk("bp_issued", 64'(io.io_rays_issued), 64'(3));
        step();

        // Protocol: start mid-RUN ignored, spurious done flags err
        dmode = 0; io.io_issue_ready = '0;
        start_frame(6);
        step();
        io.io_num_rays = 99; io.io_start = 1'b1;
        step();
        io.io_start = 1'b0;
        chk("midstart_err", 64'(io.io_err), 64'(0));
        chk("midstart_busy", 64'(io.io_busy), 64'(1));
        io.io_done_valid = 2'b10;
        step();
        chk("spurious_err", 64'(io.io_err), 64'(1));
        chk("spurious_retired", 64'(io.io_rays_retired), 64'(0));
        chk("spurious_issued", 64'(io.io_rays_issued), 64'(0));
        io.io_issue_ready = '1; dmode = 1;
        wait_fin(200, "proto_timeout");
        chk("proto_issued", 64'(io.io_rays_issued), 64'(6));
        chk("proto_retired", 64'(io.io_rays_retired), 64'(6));
        dmode = 0; io.io_done_valid = 2'b01;
        step();
        chk("done_in_done_err", 64'(io.io_err), 64'(1));

        // Reset during DRAIN
        start_frame(8);
        repeat (12) step();
        chk("drain_busy", 64'(io.io_busy), 64'(1));
        chk("drain_valid", 64'(io.io_issue_valid), 64'(0));
        chk("drain_issued", 64'(io.io_rays_issued), 64'(8));
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        step();
        reset = 1'b0;
        step();
        dmode = 1;
        start_frame(2);
        wait_fin(100, "post_rst_timeout");
        chk("post_rst_issued", 64'(io.io_rays_issued), 64'(2));
        chk("post_rst_retired", 64'(io.io_rays_retired), 64'(2));
        step();

        // Randomized frames
        rdy_rand = 1;
        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(40, 1));
            rdy_pct = int'($urandom_range(100, 30));
            dmode = int'($urandom_range(2, 1));
            dly_lo = 1; dly_hi = int'($urandom_range(8, 1));
            start_frame(n);
            wait_fin(3000, "rand_timeout");
            chk("rand_issued", 64'(io.io_rays_issued), 64'(n));
            chk("rand_retired", 64'(io.io_rays_retired), 64'(n));
            repeat (2) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
